// File: rtl/mk_design_queued.sv
// mk_design_queued: operand FIFO feeding a multi-cycle multiply (MODE=0) or add
// (MODE=1) engine; the finished value is held for result/check until consumed.
module mk_design_queued #(
   parameter int W     = 5,
   parameter int DEPTH = 4,
   parameter int MODE  = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [W-1:0]           start_a,
   input  logic [W-1:0]           start_b,
   input  logic                   EN_start,
   output logic                   stready,
   input  logic [W-1:0]           result_c,
   output logic [W-1:0]           result,
   output logic                   resready,
   input  logic [W-1:0]           check_d,
   input  logic                   EN_check,
   output logic [W-1:0]           check,
   output logic                   chready,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = $clog2(W);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   logic [W-1:0]  mem_a [DEPTH];
   logic [W-1:0]  mem_b [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   state_t        state;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  acc;
   logic [W-1:0]  p;
   logic [IW-1:0] iter;
   logic [W-1:0]  partial;
   logic          push;
   logic          pop;

   // stready deliberately ignores a same-cycle pop: a full FIFO never accepts.
   assign stready = (count != CW'(DEPTH));
   assign push    = EN_start && stready;
   assign pop     = (count != '0) &&
                    ((state == S_IDLE) || ((state == S_DONE) && EN_check));
   assign partial = op_b[iter] ? (op_a << iter) : '0;

   assign resready = (state == S_DONE);
   assign chready  = resready;
   assign result   = resready ? (p + result_c) : '0;
   assign check    = chready ? (p ^ check_d) : '0;

   // NOTE: the operand storage is cleared on reset like every other register so
   // nothing stale survives; at this depth it is flops, not a RAM macro.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] <= '0;
            mem_b[i] <= '0;
         end
      end else if (push) begin
         mem_a[wr_ptr] <= start_a;
         mem_b[wr_ptr] <= start_b;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of the others regardless of order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         op_a  <= '0;
         op_b  <= '0;
         acc   <= '0;
         iter  <= '0;
         p     <= '0;
      end else if (pop) begin
         // Load straight from DONE as well as IDLE, avoiding an idle bubble.
         op_a  <= mem_a[rd_ptr];
         op_b  <= mem_b[rd_ptr];
         acc   <= '0;
         iter  <= '0;
         state <= S_BUSY;
      end else begin
         case (state)
            S_BUSY: begin
               if (MODE == 1) begin
                  p     <= op_a + op_b;
                  state <= S_DONE;
               end else begin
                  acc  <= acc + partial;
                  iter <= iter + IW'(1);
                  if (iter == IW'(W - 1)) begin
                     p     <= acc + partial;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (EN_check) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mk_design_queued.md
Name: mk_design_queued

Overview:
- Parametrised successor to the single-shot start/result/check method block.
- `start` enqueues operand pairs into a DEPTH-entry FIFO. A multi-cycle compute engine then drains the FIFO one pair at a time.
- The engine holds each finished value for the `result` value method and the `check` actionvalue method; `check` consumes the value.
- Sits behind Bluespec-style enable/ready method ports.

Parameters:
- W, 5, operand/result width in bits (2..32).
- DEPTH, 4, operand FIFO entries (power of two, >= 2).
- MODE, 0, 0 = shift-add multiply (W busy cycles); 1 = add (1 busy cycle).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start_a  input  W  operand A for start.
- start_b  input  W  operand B for start.
- EN_start  input  1  start enable; honoured only when stready=1.
- stready  output  1  start ready: FIFO not full.
- result_c  input  W  addend for the result value method.
- result  output  W  (P + result_c) mod 2^W when resready, else 0; combinational.
- resready  output  1  engine in DONE.
- check_d  input  W  mask for check.
- EN_check  input  1  check enable; consumes P; honoured only when chready=1.
- check  output  W  P ^ check_d when chready, else 0; combinational.
- chready  output  1  equals resready.
- count  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, all registers cleared immediately):
  - FIFO empty, count=0, state IDLE, P=0, iteration counter=0.
  - Outputs: stready=1, resready=0, chready=0, result=0, check=0.
  - Reset mid-BUSY or mid-DONE discards all queued pairs and the in-flight result.
- FIFO: circular, registered pointers, stready = (count != DEPTH).
  - EN_start with stready=0 is a protocol violation: ignored, no state change.
  - Push and pop in the same cycle: count unchanged. Push is still blocked when full even if a pop occurs that cycle (stready never depends on pop).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if count>0, pop head, load A/B, acc=0, iter=0 -> BUSY. A pair enqueued at edge t is loaded at edge t+1.
  - BUSY, MODE=0: each edge, acc += B[iter] ? (A << iter) : 0, truncated to W; iter++. When iter reaches W-1, P <= final acc -> DONE. That is W BUSY edges; resready rises after edge t+1+W.
  - BUSY, MODE=1: one edge, P <= (A+B) mod 2^W -> DONE; resready rises after edge t+2.
  - DONE: P held stable; result/check track result_c/check_d combinationally.
  - EN_check in DONE: if count>0, pop and load directly -> BUSY (no IDLE bubble); else -> IDLE.
  - EN_check outside DONE is ignored.
- All arithmetic is unsigned, modulo 2^W; no carry-out.
- EN_start and EN_check in the same cycle are both honoured independently.

Test Plan:
1. MODE=0, W=5: start a=3 b=5, wait for resready -> result_c=1 gives result=16; check_d=31 gives check=16. EN_check -> resready=0 next cycle.
2. Latency and overflow, MODE=0: start a=7 b=6 at edge t -> resready first 1 after edge t+6. P=42 mod 32=10; result_c=31 -> result=9.
3. Full:
   - 5 back-to-back starts with no check -> after 5th edge count=4, stready=0.
   - A 6th EN_start is ignored: count stays 4 and the FIFO contents are unchanged.
   - One EN_check -> next pair is loaded in the same edge (state BUSY), count=3, stready=1.
4. Simultaneous: with FIFO count=2 and DONE, assert EN_start and EN_check in one cycle -> count stays 2, state BUSY, the new pair is at the tail.
5. Reset mid-operation: assert RST during BUSY with 3 queued -> immediately count=0, resready=0, stready=1. After release, one start a=2 b=2 yields P=4.
6. MODE=1: start a=20 b=15 at edge t -> resready after edge t+2, result with result_c=0 is 3. Back-to-back pairs complete every 2 cycles under continuous EN_check.
